input_debounce_sync: RTL
========================

Name: input_debounce_sync

Overview:
- Conditions a raw, asynchronous, possibly bouncing single-bit input into a clean, clock-synchronous level.
- Sits directly upstream of the edge detector and drives its a_i input, so that rising_edge_o/falling_edge_o pulse once per real transition.
- Consists of a multi-flop synchronizer followed by a stability counter with a small state machine.
- The output level changes only after the synchronized input has disagreed with it for STABLE_CYCLES consecutive clocks.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal: >= 2).
- STABLE_CYCLES, 4, consecutive mismatching samples required before clean_o flips (legal: >= 1).
- CNT_W, clog2(STABLE_CYCLES)+1, stability counter width (derived; not overridden by users).
- RESET_VAL, 1'b0, reset level of every synchronizer flop and of clean_o.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- raw_i  input  1  raw asynchronous input (switch or pin); no timing relation to clk.
- clean_o  output  1  debounced, synchronized level; feeds the edge detector's a_i.
- busy_o  output  1  high while a candidate transition is being qualified (state QUAL).

Behaviour:
- One clock (clk); reset is synchronous and active-high, named reset. There is no asynchronous reset path.
- Reset values:
  - all synchronizer flops = RESET_VAL
  - clean_o = RESET_VAL
  - counter = 0
  - state = IDLE
  - busy_o = 0
- Reset asserted mid-qualification aborts it: the counter is discarded and clean_o is forced to RESET_VAL on that edge.
- Synchronizer:
  - raw_i shifts through SYNC_STAGES flops; sync_q is the last stage.
  - No logic is permitted between the stages.
- FSM, two states:
  - IDLE, when sync_q == clean_o: counter held at 0, busy_o = 0.
  - IDLE, when sync_q != clean_o: go to QUAL with counter = 1. If STABLE_CYCLES == 1, toggle clean_o on this edge instead and stay in IDLE.
  - QUAL, when sync_q == clean_o: glitch is rejected; go to IDLE, counter = 0, clean_o unchanged.
  - QUAL, when sync_q != clean_o and counter == STABLE_CYCLES-1: toggle clean_o, counter = 0, go to IDLE.
  - QUAL, when sync_q != clean_o otherwise: counter += 1.
  - busy_o = (state == QUAL), registered.
- Latency:
  - Take E0 as the first rising edge that samples a held new value of raw_i.
  - clean_o shows the new value after edge E0+SYNC_STAGES+STABLE_CYCLES-1, i.e. 6 edges inclusive with default parameters.
- Pulse rejection: a change in sync_q lasting fewer than STABLE_CYCLES cycles never reaches clean_o.
- Counter arithmetic: unsigned, width CNT_W; it never exceeds STABLE_CYCLES-1, so it cannot wrap.
- Back-to-back transitions: after a flip, the next opposite transition needs a full new qualification window. clean_o can change at most once every STABLE_CYCLES cycles.
- clean_o is driven directly from a flop, with no combinational path from raw_i.

Decomposition:
- Shared package/header (debounce_pkg):
  - FSM state encodings IDLE = 1'b0, QUAL = 1'b1
  - the clog2 constant function used to derive CNT_W
- One natural sub-module: sync_chain (parameter SYNC_STAGES; ports clk, reset, d_i, q_o; reset value RESET_VAL).
  - It is reusable for other asynchronous inputs in the design.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: reset=1 for 2 cycles with raw_i=1 -> clean_o=0 and busy_o=0 throughout reset and on the first cycle after release.
- Clean step (defaults): after reset, raw_i 0->1 held -> clean_o rises exactly 6 edges after the first sampling edge; busy_o high for the 3 cycles before the flip.
- Glitch: raw_i=1 for 3 cycles, then 0 -> clean_o stays 0; busy_o pulses and returns to 0.
- Bounce then settle: raw_i pattern 1,0,1,1,0,1 then held 1 -> clean_o rises only after the first run of 4 consecutive synchronized 1s; the edge detector downstream shows exactly one rising_edge_o pulse.
- Reset mid-qualification: raw_i=1 held, reset pulsed for 1 cycle while busy_o=1 -> clean_o=0 and counter restarts; clean_o rises 6 edges after the first post-reset sample.
- STABLE_CYCLES=1, SYNC_STAGES=2: raw_i toggled every 2 cycles -> clean_o follows raw_i with a fixed 2-edge latency and busy_o never asserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encoding and constant helpers for the input debouncer
//
// Purpose: state encoding of the debounce FSM and the clog2 constant
//          function used to size the stability counter.
// Ports:   none (package).

package debounce_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } state_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for a single asynchronous bit
//
// Purpose: brings an asynchronous bit into the clk domain through a plain
//          shift chain of SYNC_STAGES flops with nothing between stages.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, loads RESET_VAL into every stage
//   d_i    in   asynchronous input bit
//   q_o    out  synchronized bit (last stage)

module sync_chain #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stages <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/input_debounce_sync.sv
// rtl/input_debounce_sync.sv - synchronizer plus stability-counter debouncer
//
// Purpose: turns a raw, bouncing, asynchronous bit into a clean level that
//          only changes after the synchronized input has disagreed with it
//          for STABLE_CYCLES consecutive clocks.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   raw_i    in   raw asynchronous input
//   clean_o  out  debounced level, straight from a flop
//   busy_o   out  high while a candidate transition is being qualified

module input_debounce_sync
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic busy_o
);

    localparam int             CNT_W    = clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_sync_q;
    logic             w_mismatch;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_clean;
    logic             w_next_clean;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw_i),
        .q_o   (w_sync_q)
    );

    assign w_mismatch = (w_sync_q != r_clean);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clean <= RESET_VAL;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_clean <= w_next_clean;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_clean = r_clean;
        case (r_state)
            IDLE: begin
                w_next_cnt = '0;
                if (w_mismatch) begin
                    // A one-cycle window qualifies on the very first mismatch.
                    if (STABLE_CYCLES == 1) begin
                        w_next_clean = ~r_clean;
                    end else begin
                        w_next_state = QUAL;
                        w_next_cnt   = CNT_ONE;
                    end
                end
            end
            QUAL: begin
                if (!w_mismatch) begin
                    // Input fell back before the window closed: glitch.
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_clean = ~r_clean;
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign clean_o = r_clean;
    // r_state is itself a flop, so busy_o is registered.
    assign busy_o  = (r_state == QUAL);

endmodule
